// File: rtl/ah_router_pkg.sv
// Shared types and helpers for the client router: buffer state encoding,
// default widths and the one-hot select check.
package ah_router_pkg;

  localparam int unsigned N_CLIENTS_DEF = 8;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned SEL_MAX_W     = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // Selects narrower than SEL_MAX_W are zero-extended by the caller.
  function automatic logic is_onehot(input logic [SEL_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

endpackage

// File: rtl/ah_router_skid.sv
// Two-entry skid buffer: the output register feeds the consumer, the skid
// register absorbs one extra packet so upstream ready is purely registered.
module ah_router_skid
  import ah_router_pkg::*;
#(
  parameter int unsigned W = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          out_d   = push_data;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          out_d = push_data;
        end else if (push) begin
          state_d = ST_TWO;
          skid_d  = push_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    full      = (state_q == ST_TWO);
    empty     = (state_q == ST_EMPTY);
    head_data = out_q;
  end

endmodule

// File: rtl/ah_client_router.sv
// Client router: classifies decoded packets, drops and counts bad ones, and
// steers good ones through a skid buffer to one of N_CLIENTS ports.
module ah_client_router
  import ah_router_pkg::*;
#(
  parameter int unsigned N_CLIENTS = N_CLIENTS_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CLIENTS-1:0] in_sel,
  input  logic                 in_dec_err,
  input  logic [DATA_W-1:0]    in_data,
  output logic [N_CLIENTS-1:0] out_valid,
  input  logic [N_CLIENTS-1:0] out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 err_pulse,
  output logic [N_CLIENTS-1:0] err_sel,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  logic [SEL_MAX_W-1:0]        sel_ext;
  logic                        good, accept, push, drop, pop;
  logic                        full, empty;
  logic [N_CLIENTS-1:0]        head_sel;
  logic [DATA_W-1:0]           head_data;

  logic                        err_pulse_q, err_pulse_d;
  logic [N_CLIENTS-1:0]        err_sel_q, err_sel_d;
  logic [ERR_CNT_W-1:0]        err_cnt_q, err_cnt_d;

  always_comb begin
    sel_ext                = '0;
    sel_ext[N_CLIENTS-1:0] = in_sel;
  end

  assign good   = ~in_dec_err & is_onehot(sel_ext);
  assign accept = in_valid & in_ready;
  assign push   = accept & good;
  assign drop   = accept & ~good;

  ah_router_skid #(
    .W(N_CLIENTS + DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({in_sel, in_data}),
    .pop       (pop),
    .head_data ({head_sel, head_data}),
    .full      (full),
    .empty     (empty)
  );

  assign in_ready  = ~full;
  assign out_valid = empty ? '0 : head_sel;
  assign out_data  = head_data;
  assign pop       = |(out_valid & out_ready);

  // A clear coinciding with a drop counts that drop, so the result is 1.
  always_comb begin
    err_pulse_d = drop;
    err_sel_d   = drop ? in_sel : err_sel_q;
    err_cnt_d   = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = drop ? {{(ERR_CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (drop && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_sel_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_pulse_d;
      err_sel_q   <= err_sel_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_sel   = err_sel_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ah_client_router.sv
// Directed vector table plus hand sequences and a randomized scoreboard for
// ah_client_router (ERR_CNT_W=4 so saturation is reachable).
module tb_ah_client_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_sel;
  logic        in_dec_err;
  logic [31:0] in_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [31:0] out_data;
  logic        err_pulse;
  logic [7:0]  err_sel;
  logic [3:0]  err_cnt;
  logic        err_clr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ah_client_router #(
    .N_CLIENTS(8),
    .DATA_W   (32),
    .ERR_CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_dec_err(in_dec_err),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_pulse (err_pulse),
    .err_sel   (err_sel),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  typedef struct {
    logic        v;
    logic [7:0]  sel;
    logic        derr;
    logic [31:0] data;
    logic [7:0]  rdy;
    logic        clr;
    logic [7:0]  e_ov;
    logic [31:0] e_od;
    logic        e_ir;
    logic        e_pulse;
    logic [3:0]  e_cnt;
    logic [7:0]  e_esel;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] sel, input logic derr,
                       input logic [31:0] data, input logic [7:0] rdy, input logic clr);
    in_valid   = v;
    in_sel     = sel;
    in_dec_err = derr;
    in_data    = data;
    out_ready  = rdy;
    err_clr    = clr;
  endtask

  logic [39:0] sb[$];
  logic [39:0] exp_pkt;
  int unsigned seq_data;
  int unsigned r;
  int unsigned drain;

  initial begin
    // inputs, expected outputs after the following rising edge
    vecs[0]  = '{1'b1, 8'h04, 1'b0, 32'hA5A5_0001, 8'hFF, 1'b0, 8'h04, 32'hA5A5_0001, 1'b1, 1'b0, 4'd0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 32'h0,         8'hFF, 1'b0, 8'h00, 32'hA5A5_0001, 1'b1, 1'b0, 4'd0, 8'h00};
    vecs[2]  = '{1'b1, 8'h04, 1'b0, 32'h0000_0001, 8'hFB, 1'b0, 8'h04, 32'h0000_0001, 1'b1, 1'b0, 4'd0, 8'h00};
    vecs[3]  = '{1'b1, 8'h04, 1'b0, 32'h0000_0002, 8'hFB, 1'b0, 8'h04, 32'h0000_0001, 1'b0, 1'b0, 4'd0, 8'h00};
    vecs[4]  = '{1'b1, 8'h04, 1'b0, 32'h0000_0003, 8'hFB, 1'b0, 8'h04, 32'h0000_0001, 1'b0, 1'b0, 4'd0, 8'h00};
    vecs[5]  = '{1'b1, 8'h04, 1'b0, 32'h0000_0003, 8'hFF, 1'b0, 8'h04, 32'h0000_0002, 1'b1, 1'b0, 4'd0, 8'h00};
    vecs[6]  = '{1'b1, 8'h04, 1'b0, 32'h0000_0003, 8'hFF, 1'b0, 8'h04, 32'h0000_0003, 1'b1, 1'b0, 4'd0, 8'h00};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 32'h0,         8'hFF, 1'b0, 8'h00, 32'h0000_0003, 1'b1, 1'b0, 4'd0, 8'h00};
    vecs[8]  = '{1'b1, 8'h04, 1'b1, 32'hDEAD_0001, 8'hFF, 1'b0, 8'h00, 32'h0000_0003, 1'b1, 1'b1, 4'd1, 8'h04};
    vecs[9]  = '{1'b1, 8'h00, 1'b0, 32'hDEAD_0002, 8'hFF, 1'b0, 8'h00, 32'h0000_0003, 1'b1, 1'b1, 4'd2, 8'h00};
    vecs[10] = '{1'b1, 8'h41, 1'b0, 32'hDEAD_0003, 8'hFF, 1'b0, 8'h00, 32'h0000_0003, 1'b1, 1'b1, 4'd3, 8'h41};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 32'h0,         8'hFF, 1'b0, 8'h00, 32'h0000_0003, 1'b1, 1'b0, 4'd3, 8'h41};
    vecs[12] = '{1'b1, 8'h80, 1'b0, 32'h0000_00B0, 8'h00, 1'b0, 8'h80, 32'h0000_00B0, 1'b1, 1'b0, 4'd3, 8'h41};
    vecs[13] = '{1'b1, 8'h03, 1'b0, 32'hBAD0_BAD0, 8'h00, 1'b0, 8'h80, 32'h0000_00B0, 1'b1, 1'b1, 4'd4, 8'h03};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 32'h0,         8'h80, 1'b0, 8'h00, 32'h0000_00B0, 1'b1, 1'b0, 4'd4, 8'h03};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 32'h0,         8'h00, 1'b1, 8'h00, 32'h0000_00B0, 1'b1, 1'b0, 4'd0, 8'h03};

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 32'h0, 8'h00, 1'b0);
    #2;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_err_pulse", 64'(err_pulse), 64'd0);
    chk("rst_err_sel",   64'(err_sel),   64'd0);
    chk("rst_err_cnt",   64'(err_cnt),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].derr, vecs[i].data, vecs[i].rdy, vecs[i].clr);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("v%0d_out_data", i),  64'(out_data),  64'(vecs[i].e_od));
      chk($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].e_ir));
      chk($sformatf("v%0d_err_pulse", i), 64'(err_pulse), 64'(vecs[i].e_pulse));
      chk($sformatf("v%0d_err_cnt", i),   64'(err_cnt),   64'(vecs[i].e_cnt));
      chk($sformatf("v%0d_err_sel", i),   64'(err_sel),   64'(vecs[i].e_esel));
    end

    // Saturation of the 4-bit drop counter, then clear coinciding with a drop.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'h01, 1'b1, 32'(i), 8'hFF, 1'b0);
      @(negedge clk);
    end
    chk("sat_err_cnt", 64'(err_cnt), 64'd15);
    chk("sat_out_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 8'h22, 1'b0, 32'h0, 8'hFF, 1'b1);
    @(negedge clk);
    chk("clr_drop_cnt",   64'(err_cnt),   64'd1);
    chk("clr_drop_pulse", 64'(err_pulse), 64'd1);
    chk("clr_drop_sel",   64'(err_sel),   64'h22);
    drive(1'b0, 8'h00, 1'b0, 32'h0, 8'hFF, 1'b0);
    @(negedge clk);
    chk("clr_drop_hold", 64'(err_cnt), 64'd1);

    // Fill to TWO, then reset mid-cycle: outputs must drop immediately.
    drive(1'b1, 8'h02, 1'b0, 32'h0000_00C1, 8'h00, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h02, 1'b0, 32'h0000_00C2, 8'h00, 1'b0);
    @(negedge clk);
    chk("two_in_ready",  64'(in_ready),  64'd0);
    chk("two_out_valid", 64'(out_valid), 64'h02);
    drive(1'b0, 8'h00, 1'b0, 32'h0, 8'hFF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_err_cnt",   64'(err_cnt),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_ov%0d", i), 64'(out_valid), 64'd0);
    end

    // Randomized traffic against a FIFO scoreboard of good packets.
    seq_data = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 7);
      case (r)
        0: drive(1'b1, 8'h01, 1'b1, 32'hEEEE_0000, 8'($urandom), 1'b0);
        1: drive(1'b1, 8'h00, 1'b0, 32'hEEEE_0001, 8'($urandom), 1'b0);
        2: drive(1'b1, 8'h81, 1'b0, 32'hEEEE_0002, 8'($urandom), 1'b0);
        3: drive(1'b0, 8'h01, 1'b0, 32'hEEEE_0003, 8'($urandom), 1'b0);
        4, 5: drive(1'b1, 8'h01, 1'b0, seq_data, 8'($urandom), 1'b0);
        default: drive(1'b1, 8'h80, 1'b0, seq_data, 8'($urandom), 1'b0);
      endcase
      #1;
      if ($countones(out_valid) > 1) chk("rand_ov_onehot", 64'(out_valid), 64'd0);
      if (|(out_valid & out_ready)) begin
        if (sb.size() == 0) begin
          chk("rand_unexpected", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_pkt = sb.pop_front();
          chk("rand_out_valid", 64'(out_valid), 64'(exp_pkt[39:32]));
          chk("rand_out_data",  64'(out_data),  64'(exp_pkt[31:0]));
        end
      end
      if (in_valid && in_ready && (r >= 4)) begin
        sb.push_back({in_sel, in_data});
        seq_data++;
      end
      @(negedge clk);
    end

    drive(1'b0, 8'h00, 1'b0, 32'h0, 8'hFF, 1'b0);
    drain = 0;
    while (out_valid != 8'h00 && drain < 40) begin
      #1;
      if (sb.size() == 0) begin
        chk("drain_unexpected", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_pkt = sb.pop_front();
        chk("drain_out_valid", 64'(out_valid), 64'(exp_pkt[39:32]));
        chk("drain_out_data",  64'(out_data),  64'(exp_pkt[31:0]));
      end
      @(negedge clk);
      drain++;
    end
    chk("drain_timeout", 64'(out_valid), 64'd0);
    chk("sb_leftover", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
